// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer write path.
package fb_pkg;
   typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_DRAIN} dt_state_t;

   // Wide enough for any depth word; consumers slice to their own width.
   localparam logic [31:0] CLEAR_DEPTH = '1;

   localparam int FRAG_ADDRWIDTH  = 15;
   localparam int FRAG_DATAWIDTH  = 12;
   localparam int FRAG_COLORWIDTH = 4;

   typedef struct packed {
      logic [FRAG_ADDRWIDTH-1:0]  addr;
      logic [FRAG_DATAWIDTH-1:0]  depth;
      logic [FRAG_COLORWIDTH-1:0] color;
   } frag_t;
endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth RAM: one write port, registered read returning old data on collision.
module depth_ram #(
   parameter int DEPTH = 19200,
   parameter int AW    = 15,
   parameter int DW    = 12
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/depth_test_unit.sv
// Read-compare-write depth test with clear sequencing; fragments nearer than stored depth reach the framebuffer.
// Optional hit/miss statistics counters are built when DEPTH_TEST_STATS_EN is defined.
module depth_test_unit
   import fb_pkg::*;
#(
   parameter int DATAWIDTH     = 12,
   parameter int COLORWIDTH    = 4,
   parameter int SCREEN_WIDTH  = 160,
   parameter int SCREEN_HEIGHT = 120,
   parameter int ADDRWIDTH     = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
   parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clear,
   output logic                  o_ready,
   input  logic [ADDRWIDTH-1:0]  i_fb_addr_write,
   input  logic                  i_fb_write_en,
   input  logic [DATAWIDTH-1:0]  i_fb_depth_data,
   input  logic [COLORWIDTH-1:0] i_fb_color_data,
   output logic [ADDRWIDTH-1:0]  o_fb_addr_write,
   output logic                  o_fb_write_en,
   output logic [COLORWIDTH-1:0] o_fb_color_data,
   output logic                  o_clear_done,
   output logic [15:0]           o_pass_count,
   output logic [15:0]           o_reject_count
);
   localparam int FB_DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT;
   localparam logic [ADDRWIDTH:0]   FB_DEPTH_W = (ADDRWIDTH+1)'(FB_DEPTH);
   localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(FB_DEPTH-1);
   localparam logic [DATAWIDTH-1:0] CLR_DEPTH  = CLEAR_DEPTH[DATAWIDTH-1:0];

   dt_state_t             state;
   logic [ADDRWIDTH-1:0]  clr_addr;
   logic                  clr_fin;
   logic                  accept, in_range, go_clear, clearing;
   logic                  s1_vld, s1_in_range;
   logic [ADDRWIDTH-1:0]  s1_addr, fwd_addr, ram_waddr;
   logic [DATAWIDTH-1:0]  s1_depth, fwd_depth, ram_rdata, stored, ram_wdata;
   logic [COLORWIDTH-1:0] s1_color;
   logic                  fwd_vld, pass, ram_we;

   assign accept   = i_fb_write_en && o_ready;
   assign in_range = {1'b0, i_fb_addr_write} < FB_DEPTH_W;
   assign clearing = (state == ST_CLEAR) && !clr_fin;

   // The RAM read for this compare was issued before the previous fragment's write landed.
   assign stored = (fwd_vld && fwd_addr == s1_addr) ? fwd_depth : ram_rdata;
   assign pass   = s1_vld && s1_in_range && (s1_depth < stored);

   assign go_clear = (state == ST_RUN && i_clear && !(accept || s1_vld)) ||
                     (state == ST_DRAIN && !s1_vld);

   assign ram_we    = clearing || pass;
   assign ram_waddr = clearing ? clr_addr : s1_addr;
   assign ram_wdata = clearing ? CLR_DEPTH : s1_depth;

   depth_ram #(.DEPTH(FB_DEPTH), .AW(ADDRWIDTH), .DW(DATAWIDTH)) u_ram (
      .clk   (clk),
      .re    (accept && in_range),
      .raddr (i_fb_addr_write),
      .rdata (ram_rdata),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_CLEAR;
         clr_addr      <= '0;
         clr_fin       <= 1'b0;
         o_ready       <= 1'b0;
         o_clear_done  <= 1'b0;
         o_fb_write_en <= 1'b0;
         s1_vld        <= 1'b0;
         fwd_vld       <= 1'b0;
      end else begin
         o_clear_done  <= 1'b0;
         o_fb_write_en <= ram_we;
         s1_vld        <= accept;
         fwd_vld       <= pass;
         if (go_clear) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
         end
         case (state)
            ST_CLEAR: begin
               if (clr_fin) begin
                  state        <= ST_RUN;
                  clr_fin      <= 1'b0;
                  o_ready      <= 1'b1;
                  o_clear_done <= 1'b1;
               end else if (clr_addr == LAST_ADDR) begin
                  clr_fin <= 1'b1;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            ST_RUN: begin
               if (i_clear) begin
                  o_ready <= 1'b0;
                  if (accept || s1_vld) state <= ST_DRAIN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      s1_in_range     <= in_range;
      s1_addr         <= i_fb_addr_write;
      s1_depth        <= i_fb_depth_data;
      s1_color        <= i_fb_color_data;
      fwd_addr        <= s1_addr;
      fwd_depth       <= s1_depth;
      o_fb_addr_write <= ram_waddr;
      o_fb_color_data <= (state == ST_CLEAR) ? CLEAR_COLOR : s1_color;
   end

`ifdef DEPTH_TEST_STATS_EN
   logic reject;
   assign reject = s1_vld && !pass;

   always_ff @(posedge clk) begin
      if (rst || go_clear) begin
         o_pass_count   <= '0;
         o_reject_count <= '0;
      end else begin
         if (pass && o_pass_count != 16'hFFFF)     o_pass_count   <= o_pass_count + 16'd1;
         if (reject && o_reject_count != 16'hFFFF) o_reject_count <= o_reject_count + 16'd1;
      end
   end
`else
   assign o_pass_count   = '0;
   assign o_reject_count = '0;
`endif
endmodule

// File: tb/tb_depth_test_unit.sv
// Randomized + directed bench for depth_test_unit against a sequential depth-buffer model.
module tb_depth_test_unit;
   import fb_pkg::*;

   localparam int AW = 15, DW = 12, CW = 4, FB_DEPTH = 19200;
`ifdef DEPTH_TEST_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, i_clear, o_ready, i_fb_write_en, o_fb_write_en, o_clear_done;
   logic [AW-1:0] i_fb_addr_write, o_fb_addr_write;
   logic [DW-1:0] i_fb_depth_data;
   logic [CW-1:0] i_fb_color_data, o_fb_color_data;
   logic [15:0]   o_pass_count, o_reject_count;

   depth_test_unit dut (
      .clk             (clk),
      .rst             (rst),
      .i_clear         (i_clear),
      .o_ready         (o_ready),
      .i_fb_addr_write (i_fb_addr_write),
      .i_fb_write_en   (i_fb_write_en),
      .i_fb_depth_data (i_fb_depth_data),
      .i_fb_color_data (i_fb_color_data),
      .o_fb_addr_write (o_fb_addr_write),
      .o_fb_write_en   (o_fb_write_en),
      .o_fb_color_data (o_fb_color_data),
      .o_clear_done    (o_clear_done),
      .o_pass_count    (o_pass_count),
      .o_reject_count  (o_reject_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    due;
      bit    pass;
      frag_t f;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mdepth [FB_DEPTH];
   int            cyc, n_chk, n_err, mpass, mrej;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] exp_stat(input int v);
      if (!STATS) return 32'd0;
      return (v > 65535) ? 32'd65535 : 32'(v);
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_run();
      exp_t r;
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         check_val("fb_we", 32'(o_fb_write_en), 32'(r.pass));
         if (r.pass) begin
            check_val("fb_addr", 32'(o_fb_addr_write), 32'(r.f.addr));
            check_val("fb_color", 32'(o_fb_color_data), 32'(r.f.color));
            mpass++;
         end else begin
            mrej++;
         end
      end else begin
         check_val("fb_we_idle", 32'(o_fb_write_en), 32'd0);
      end
      check_val("pass_cnt", 32'(o_pass_count), exp_stat(mpass));
      check_val("reject_cnt", 32'(o_reject_count), exp_stat(mrej));
   endtask

   // Drive one cycle of stimulus; the model resolves each accepted fragment in order.
   task automatic frag(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input bit clr);
      exp_t r;
      i_fb_write_en   = we;
      i_fb_addr_write = addr;
      i_fb_depth_data = d;
      i_fb_color_data = c;
      i_clear         = clr;
      if (we && o_ready) begin
         r.due     = cyc + 2;
         r.f.addr  = addr;
         r.f.depth = d;
         r.f.color = c;
         r.pass    = 1'b0;
         if (int'(addr) < FB_DEPTH) begin
            if (d < mdepth[addr]) begin
               r.pass       = 1'b1;
               mdepth[addr] = d;
            end
         end
         q.push_back(r);
      end
      adv();
      i_fb_write_en = 1'b0;
      i_clear       = 1'b0;
      check_run();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) frag(1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic wait_clear(input bit poke);
      int w, bad;
      w   = 0;
      bad = 0;
      while (o_fb_write_en !== 1'b1 && w < 8) begin
         if (o_ready !== 1'b0) bad++;
         adv();
         w++;
      end
      check_val("clear_start", 32'(w < 8), 32'd1);
      for (int a = 0; a < FB_DEPTH; a++) begin
         if (o_fb_write_en !== 1'b1 || o_fb_addr_write !== AW'(a) || o_fb_color_data !== '0 ||
             o_ready !== 1'b0 || o_clear_done !== 1'b0) bad++;
         if (poke && a == 100) i_clear = 1'b1;
         adv();
         i_clear = 1'b0;
      end
      check_val("clear_bad_cycles", 32'(bad), 32'd0);
      check_val("clear_done", 32'(o_clear_done), 32'd1);
      check_val("ready_after_clear", 32'(o_ready), 32'd1);
      check_val("we_after_clear", 32'(o_fb_write_en), 32'd0);
      for (int a = 0; a < FB_DEPTH; a++) mdepth[a] = '1;
      mpass = 0;
      mrej  = 0;
      q.delete();
      check_val("pass_cnt_cleared", 32'(o_pass_count), 32'd0);
      check_val("reject_cnt_cleared", 32'(o_reject_count), 32'd0);
      adv();
      check_val("clear_done_pulse", 32'(o_clear_done), 32'd0);
      check_val("ready_hold", 32'(o_ready), 32'd1);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      i_fb_write_en = 1'b0;
      i_clear       = 1'b0;
      repeat (3) adv();
      rst = 1'b0;
      check_val("rst_ready", 32'(o_ready), 32'd0);
      check_val("rst_fb_we", 32'(o_fb_write_en), 32'd0);
      check_val("rst_clear_done", 32'(o_clear_done), 32'd0);
      check_val("rst_pass_cnt", 32'(o_pass_count), 32'd0);
      check_val("rst_reject_cnt", 32'(o_reject_count), 32'd0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int            sel;
   logic [AW-1:0] ra;

   initial begin
      cyc = 0; n_chk = 0; n_err = 0; mpass = 0; mrej = 0;
      rst = 1'b1; i_clear = 1'b0; i_fb_write_en = 1'b0;
      i_fb_addr_write = '0; i_fb_depth_data = '0; i_fb_color_data = '0;

      do_reset();
      repeat (50) adv();
      check_val("mid_clear_we", 32'(o_fb_write_en), 32'd1);
      do_reset();
      wait_clear(1'b0);

      // Directed depth-test cases
      frag(1'b1, 15'd100, 12'h800, 4'd5, 1'b0);
      idle(2);
      frag(1'b1, 15'd100, 12'h199, 4'd7, 1'b0);
      frag(1'b1, 15'd100, 12'h800, 4'd3, 1'b0);
      frag(1'b1, 15'd200, 12'h800, 4'd1, 1'b0);
      frag(1'b1, 15'd200, 12'h900, 4'd2, 1'b0);
      frag(1'b1, 15'd201, 12'h900, 4'd3, 1'b0);
      frag(1'b1, 15'd201, 12'h800, 4'd4, 1'b0);
      frag(1'b1, 15'd100, 12'h199, 4'd6, 1'b0);
      frag(1'b1, 15'd19200, 12'h001, 4'd9, 1'b0);
      frag(1'b1, 15'd32767, 12'h000, 4'd9, 1'b0);
      frag(1'b1, 15'd19199, 12'h000, 4'd8, 1'b0);
      frag(1'b1, 15'd0, 12'hFFF, 4'd2, 1'b0);
      idle(3);

      // Random traffic on a few hot addresses to exercise back-to-back hazards
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            6:       ra = 15'd19199;
            7:       ra = 15'd19200;
            8:       ra = 15'd0;
            9:       ra = AW'($urandom_range(0, 32767));
            default: ra = AW'(300 + sel % 4);
         endcase
         frag(($urandom_range(0, 3) != 0), ra, DW'($urandom_range(0, 4095)),
              CW'($urandom_range(0, 15)), 1'b0);
      end
      idle(3);

      // Clear with a fragment in flight: its write must land before the clear
      frag(1'b1, 15'd50, 12'h123, 4'd11, 1'b1);
      check_val("ready_drop", 32'(o_ready), 32'd0);
      idle(1);
      check_val("ready_drain", 32'(o_ready), 32'd0);
      idle(1);
      wait_clear(1'b0);
      frag(1'b1, 15'd50, 12'hFFE, 4'd2, 1'b0);
      idle(3);

      // Clear with an empty pipeline; a mid-clear request is ignored
      frag(1'b0, '0, '0, '0, 1'b1);
      check_val("ready_drop_direct", 32'(o_ready), 32'd0);
      wait_clear(1'b1);
      frag(1'b1, 15'd100, 12'hFFE, 4'd12, 1'b0);
      frag(1'b1, 15'd101, 12'hFFF, 4'd13, 1'b0);
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/depth_test_unit.md
# depth_test_unit

Consumer side of the rasterizer's fragment-write interface: accepts the `(address, depth, color)` fragment stream the rasterizer emits for the framebuffer. It owns the depth buffer RAM and performs a read-compare-write depth test per fragment. Only fragments nearer than the stored depth are forwarded as color writes to the framebuffer. It also sequences full-screen clears, both after reset and on request.

## Interface
Parameters:
- `DATAWIDTH`, 12: depth word width, unsigned; smaller is nearer.
- `COLORWIDTH`, 4: palette index width.
- `SCREEN_WIDTH`, 160: pixels per line.
- `SCREEN_HEIGHT`, 120: lines.
- `ADDRWIDTH`, `$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)`: pixel address width.
- `CLEAR_COLOR`, 0: palette index written during clear.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_clear` in 1: single-cycle clear request.
- `o_ready` out 1: fragment accepted when `i_fb_write_en && o_ready`.
- `i_fb_addr_write` in ADDRWIDTH: fragment pixel address.
- `i_fb_write_en` in 1: fragment valid.
- `i_fb_depth_data` in DATAWIDTH: fragment depth.
- `i_fb_color_data` in COLORWIDTH: fragment color.
- `o_fb_addr_write` out ADDRWIDTH: framebuffer write address.
- `o_fb_write_en` out 1: framebuffer write strobe.
- `o_fb_color_data` out COLORWIDTH: framebuffer write data.
- `o_clear_done` out 1: one-cycle pulse when a clear completes.
- `o_pass_count` out 16: fragments passed (see Configuration).
- `o_reject_count` out 16: fragments rejected or dropped (see Configuration).

## Operation
- Constant: `FB_DEPTH = SCREEN_WIDTH*SCREEN_HEIGHT`.
- Constant: `CLEAR_DEPTH` = all ones.
- States:
  - CLEAR: writes `CLEAR_DEPTH` to depth RAM and `CLEAR_COLOR` to the framebuffer, one address per cycle, for addresses 0..`FB_DEPTH`-1. After the last address, goes to RUN and pulses `o_clear_done`.
  - RUN: `o_ready`=1. Accepts one fragment per cycle.
  - DRAIN: entered from RUN on `i_clear` if a fragment is in flight. `o_ready`=0. Goes to CLEAR once the in-flight fragment has completed.
- `i_clear` in RUN with an empty pipeline goes directly to CLEAR.
- `i_clear` while in CLEAR or DRAIN is ignored.
- Depth test:
  - Pass iff `i_fb_depth_data < stored` (unsigned, strict).
  - Equal depth is rejected.
  - On pass: the depth RAM is updated and a framebuffer write is emitted.
- Addresses `>= FB_DEPTH` are dropped: no RAM access, no output, counted as reject.
- Read-after-write hazard:
  - A fragment compared in cycle t+1 may have read stale data when the fragment compared in cycle t had the same address.
  - In that case the compare stage uses the forwarded depth of the earlier fragment if it passed.
  - Only a one-deep hazard exists.

## Timing
- Reset:
  - `o_fb_write_en`=0, `o_ready`=0, `o_clear_done`=0.
  - Counters cleared.
  - Clear address set to 0; state set to CLEAR.
  - `rst` asserted mid-clear restarts the clear from address 0.
  - Any in-flight fragment is discarded.
- Fragment path:
  - Fragment accepted in cycle t; the RAM read address is applied combinationally in t.
  - Read data is valid in t+1, where the compare occurs.
  - The RAM write is committed at the end of t+1.
  - `o_fb_*` is registered and valid in t+2. Latency is 2 cycles.
  - Throughput is 1 fragment per cycle.
- Clear path:
  - `o_fb_write_en` is high for `FB_DEPTH` consecutive cycles with ascending addresses.
  - `o_ready` rises in the cycle after the last clear write.
  - `o_clear_done` pulses in that same cycle.
- DRAIN lasts at most 2 cycles.
- `o_ready` drops in the cycle after `i_clear` is sampled.

## Configuration
- `DEPTH_TEST_STATS_EN` defined:
  - `o_pass_count` and `o_reject_count` are 16-bit saturating counters.
  - Each increments in the compare cycle.
  - Both zero on reset and on entry to CLEAR.
- `DEPTH_TEST_STATS_EN` undefined:
  - Both ports are tied to 0.
  - No counter logic is generated.

## Structure
- Shared package `fb_pkg` holds:
  - State enum typedef `dt_state_t` (CLEAR, RUN, DRAIN).
  - `CLEAR_DEPTH`.
  - A fragment struct typedef (addr, depth, color).
- Sub-module `depth_ram`:
  - Simple dual-port, `FB_DEPTH` x `DATAWIDTH`.
  - 1-cycle registered read, read-old-data on same-address collision.
  - One write port.

## Test plan
- Reset, then idle:
  - `o_ready`=0 for 19200 cycles.
  - `o_fb_write_en` high with addresses 0..19199 and color 0.
  - Then `o_clear_done` pulses once and `o_ready`=1.
- Fragment addr 100, depth 0x800, color 5 → exactly 2 cycles later: `o_fb_write_en`=1, addr 100, color 5.
- Then addr 100 depth 0x199 color 7 → written. Then addr 100 depth 0x800 color 3 → no write; reject count +1 with stats enabled.
- Consecutive cycles at addr 200 with depth 0x800 then 0x900 → only the first is written (forwarding). With 0x900 then 0x800 → both written.
- Fragment at stored depth, equal → rejected. Addr 19200 → dropped; no RAM or framebuffer activity.
- `i_clear` asserted while a fragment is in flight:
  - The in-flight fragment's write appears.
  - `o_ready` stays low through DRAIN and the full 19200-cycle clear.
  - A subsequent fragment at depth 0xFFE passes.
